// File: rtl/ram_ctrl_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_ctrl_param_if                                             |
// | Purpose  : Request/response bundle between a bus master and the          |
// |            ram_ctrl_param memory controller.                             |
// | Signals  : req, we, addr, wdata      master -> controller                |
// |            ready, done, rdata        controller -> master                |
// | Modports : master (drives requests), slave (the controller side)         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface ram_ctrl_param_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) ();
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic              done;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ready, done, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ready, done, rdata
   );
endinterface
`default_nettype wire

// File: rtl/ram_ctrl_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_ctrl_param                                                |
// | Purpose  : Parametrised single-port synchronous RAM with a               |
// |            req/ready/done handshake, programmable wait states and an     |
// |            optional fill sequence that runs after every reset.           |
// | Ports    : clk   - clock, rising edge                                    |
// |            rst   - synchronous reset, active-high                        |
// |            bus   - ram_ctrl_param_if.slave (req/we/addr/wdata in,        |
// |                    ready/done/rdata out)                                 |
// | Params   : ADDR_W, DATA_W, WAIT_STATES (0..15), CLEAR_ON_RESET,          |
// |            CLEAR_VALUE                                                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ram_ctrl_param #(
   parameter int                ADDR_W         = 16,
   parameter int                DATA_W         = 8,
   parameter int                WAIT_STATES    = 0,
   parameter bit                CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
   input  wire logic           clk,
   input  wire logic           rst,
   ram_ctrl_param_if.slave     bus
);

   localparam int C_DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   logic [DATA_W-1:0] r_mem [0:C_DEPTH-1];

   state_t            r_state;
   logic [ADDR_W-1:0] r_ccnt;     // clear sequence address
   logic [3:0]        r_wcnt;     // remaining wait states
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_ready;
   logic              r_done;
   logic [DATA_W-1:0] r_rdata;

   logic              w_accept;
   logic              w_access;
   logic              w_acc_we;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [DATA_W-1:0] w_acc_wdata;
   logic              w_clr;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   // ready is only ever high in IDLE, the state check keeps accept tight.
   assign w_accept = bus.req && r_ready && (r_state == ST_IDLE);

   // With no wait states the array is touched at the accept edge using the
   // live bus values; otherwise the latched copies are used at the edge
   // where the wait counter reaches zero.
   assign w_access    = (WAIT_STATES == 0) ? w_accept
                                           : ((r_state == ST_WAIT) && (r_wcnt == 4'd1));
   assign w_acc_we    = (WAIT_STATES == 0) ? bus.we    : r_we;
   assign w_acc_addr  = (WAIT_STATES == 0) ? bus.addr  : r_addr;
   assign w_acc_wdata = (WAIT_STATES == 0) ? bus.wdata : r_wdata;

   assign w_clr       = (r_state == ST_CLEAR);

   // rst gates the array so an access pending at reset is dropped.
   assign w_mem_we    = !rst && (w_clr || (w_access && w_acc_we));
   assign w_mem_addr  = w_clr ? r_ccnt      : w_acc_addr;
   assign w_mem_wdata = w_clr ? CLEAR_VALUE : w_acc_wdata;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         r_ccnt  <= '0;
         r_wcnt  <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_CLEAR: begin
               r_ready <= 1'b0;
               r_ccnt  <= r_ccnt + 1'b1;
               // Leave after the top address so the counter never wraps
               // into a second pass.
               if (r_ccnt == {ADDR_W{1'b1}}) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
               end
            end
            ST_IDLE: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_we    <= bus.we;
                  r_addr  <= bus.addr;
                  r_wdata <= bus.wdata;
                  if (WAIT_STATES == 0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= ST_WAIT;
                     r_wcnt  <= 4'(WAIT_STATES);
                     r_ready <= 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               r_ready <= 1'b0;
               r_wcnt  <= r_wcnt - 4'd1;
               if (r_wcnt == 4'd1) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
            end
         endcase

         // Reads update rdata at the access edge; writes leave it alone.
         if (w_access && !w_acc_we) begin
            r_rdata <= r_mem[w_acc_addr];
         end
      end
   end

   assign bus.ready = r_ready;
   assign bus.done  = r_done;
   assign bus.rdata = r_rdata;

endmodule
`default_nettype wire
